// File: rtl/ioq_lookup_pkg.sv
// rtl/ioq_lookup_pkg.sv - shared encodings for the IOQ output-port lookup stage
package ioq_lookup_pkg;

    typedef enum logic [1:0] {
        MODE_NIC      = 2'd0,
        MODE_TABLE    = 2'd1,
        MODE_LOOPBACK = 2'd2,
        MODE_DROP_ALL = 2'd3
    } lookup_mode_e;

    typedef enum logic [1:0] {
        ST_HDR      = 2'd0,
        ST_PKT      = 2'd1,
        ST_DROP_HDR = 2'd2,
        ST_DROP_PKT = 2'd3
    } lookup_state_e;

    // Source field value that marks a header to be passed through untouched.
    localparam logic [15:0] SRC_BYPASS = 16'hffff;

endpackage

// File: rtl/ioq_dst_calc.sv
// rtl/ioq_dst_calc.sv - combinational destination-mask computation
// Ports: src_i source-port field; mode_i lookup mode; row_i table entry for
//        src_i; mask_o 16-bit one-hot/multi-hot destination mask.
module ioq_dst_calc
    import ioq_lookup_pkg::*;
#(
    parameter int NUM_PORTS = 8
) (
    input  logic [15:0]          src_i,
    input  lookup_mode_e         mode_i,
    input  logic [NUM_PORTS-1:0] row_i,
    output logic [15:0]          mask_o
);

    always_comb begin
        mask_o = '0;
        if (src_i < 16'(NUM_PORTS)) begin
            case (mode_i)
                // Flipping bit 0 pairs MAC port 2k with CPU port 2k+1.
                MODE_NIC:      mask_o = 16'h1 << (src_i ^ 16'h1);
                MODE_TABLE:    mask_o = 16'(row_i);
                MODE_LOOPBACK: mask_o = 16'h1 << src_i;
                default:       mask_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/small_fifo.sv
// rtl/small_fifo.sv - small synchronous FIFO with registered read data
// Ports: din/wr_en write side; rd_en pops into dout on the next edge;
//        nearly_full when one free slot remains; empty; reset sync active-high.
module small_fifo #(
    parameter int WIDTH          = 72,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q;
    logic [MAX_DEPTH_BITS:0]   depth_q;
    logic [WIDTH-1:0]          dout_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= din;
        end
        if (rd_en) begin
            dout_q <= mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   depth_q <= depth_q + 1'b1;
                2'b01:   depth_q <= depth_q - 1'b1;
                default: depth_q <= depth_q;
            endcase
        end
    end

    assign dout        = dout_q;
    assign empty       = (depth_q == '0);
    assign nearly_full = (depth_q >= (MAX_DEPTH_BITS+1)'(DEPTH - 1));

endmodule

// File: rtl/ioq_port_map_lookup.sv
// rtl/ioq_port_map_lookup.sv - output-port lookup stage rewriting the IOQ destination field
// Ports: in_data/in_ctrl/in_wr/in_rdy upstream; out_data/out_ctrl/out_wr/out_rdy
//        downstream; mode lookup mode; cfg_wr/cfg_addr/cfg_data table write;
//        cnt_clear, fwd_pkt_cnt, drop_pkt_cnt packet counters.
module ioq_port_map_lookup
    import ioq_lookup_pkg::*;
#(
    parameter int         DATA_WIDTH         = 64,
    parameter int         CTRL_WIDTH         = DATA_WIDTH / 8,
    parameter int         NUM_PORTS          = 8,
    parameter logic [7:0] IO_QUEUE_STAGE_NUM = 8'hff,
    parameter int         IOQ_DST_PORT_POS   = 0,
    parameter int         IOQ_SRC_PORT_POS   = 16,
    parameter int         FIFO_DEPTH_BITS    = 2,
    parameter int         CNT_WIDTH          = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic                         out_wr,
    input  logic                         out_rdy,
    input  logic [1:0]                   mode,
    input  logic                         cfg_wr,
    input  logic [$clog2(NUM_PORTS)-1:0] cfg_addr,
    input  logic [NUM_PORTS-1:0]         cfg_data,
    input  logic                         cnt_clear,
    output logic [CNT_WIDTH-1:0]         fwd_pkt_cnt,
    output logic [CNT_WIDTH-1:0]         drop_pkt_cnt
);

    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int FIFO_W = CTRL_WIDTH + DATA_WIDTH;

    logic [NUM_PORTS-1:0] map_q [NUM_PORTS];
    lookup_state_e        state_q, state_d;
    logic [CNT_WIDTH-1:0] fwd_cnt_q, drop_cnt_q;
    logic                 out_wr_q;

    logic [15:0]           src;
    logic [15:0]           mask;
    logic                  is_ioq, bypass, keep;
    logic [DATA_WIDTH-1:0] hdr_data;
    logic                  fifo_wr, fifo_rd, fifo_empty, fifo_nearly_full;
    logic [FIFO_W-1:0]     fifo_din, fifo_dout;
    logic                  fwd_inc, drop_inc;

    // Table writes land on the edge, so a same-cycle lookup sees the old row.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                map_q[i] <= '0;
            end
        end else if (cfg_wr) begin
            map_q[cfg_addr] <= cfg_data;
        end
    end

    assign src    = in_data[IOQ_SRC_PORT_POS +: 16];
    assign is_ioq = (in_ctrl == CTRL_WIDTH'(IO_QUEUE_STAGE_NUM));
    assign bypass = (src == SRC_BYPASS);
    assign keep   = bypass || (mask != '0);

    ioq_dst_calc #(
        .NUM_PORTS (NUM_PORTS)
    ) u_dst_calc (
        .src_i  (src),
        .mode_i (lookup_mode_e'(mode)),
        .row_i  (map_q[src[PORT_W-1:0]]),
        .mask_o (mask)
    );

    always_comb begin
        hdr_data = in_data;
        if (!bypass) begin
            hdr_data[IOQ_DST_PORT_POS +: 16] = mask;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fifo_wr  = 1'b0;
        fifo_din = {in_ctrl, in_data};
        fwd_inc  = 1'b0;
        drop_inc = 1'b0;
        if (in_wr) begin
            case (state_q)
                ST_HDR: begin
                    if (is_ioq) begin
                        if (keep) begin
                            fifo_wr  = 1'b1;
                            fifo_din = {in_ctrl, hdr_data};
                            fwd_inc  = 1'b1;
                        end else begin
                            drop_inc = 1'b1;
                            state_d  = ST_DROP_HDR;
                        end
                    end else begin
                        // Earlier module headers are forwarded as they come.
                        fifo_wr = 1'b1;
                        if (in_ctrl == '0) begin
                            state_d = ST_PKT;
                        end
                    end
                end
                ST_PKT: begin
                    fifo_wr = 1'b1;
                    if (in_ctrl != '0) begin
                        state_d = ST_HDR;
                    end
                end
                ST_DROP_HDR: begin
                    if (in_ctrl == '0) begin
                        state_d = ST_DROP_PKT;
                    end
                end
                ST_DROP_PKT: begin
                    if (in_ctrl != '0) begin
                        state_d = ST_HDR;
                    end
                end
                default: state_d = ST_HDR;
            endcase
        end
    end

    // Clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (reset || cnt_clear) begin
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (fwd_inc) begin
                fwd_cnt_q <= fwd_cnt_q + 1'b1;
            end
            if (drop_inc) begin
                drop_cnt_q <= drop_cnt_q + 1'b1;
            end
        end
    end

    assign fifo_rd = out_rdy && !fifo_empty;

    small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_out_fifo (
        .clk         (clk),
        .reset       (reset),
        .din         (fifo_din),
        .wr_en       (fifo_wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_wr_q <= 1'b0;
        end else begin
            out_wr_q <= fifo_rd;
        end
    end

    assign in_rdy                 = !fifo_nearly_full;
    assign out_wr                 = out_wr_q;
    assign {out_ctrl, out_data}   = fifo_dout;
    assign fwd_pkt_cnt            = fwd_cnt_q;
    assign drop_pkt_cnt           = drop_cnt_q;

endmodule

// File: tb/tb_ioq_port_map_lookup.sv
// tb/tb_ioq_port_map_lookup.sv - self-checking bench for ioq_port_map_lookup
module tb_ioq_port_map_lookup;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [1:0]  mode;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic        cnt_clear;
    logic [31:0] fwd_pkt_cnt;
    logic [31:0] drop_pkt_cnt;

    int checks = 0;
    int errors = 0;
    int exp_fwd = 0;
    int exp_drop = 0;
    logic [71:0] exp_q [$];

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] src;
        logic [15:0] dst;
        bit          fwd;
    } vec_t;
    vec_t vecs [14];

    ioq_port_map_lookup dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_wr        (in_wr),
        .in_rdy       (in_rdy),
        .out_data     (out_data),
        .out_ctrl     (out_ctrl),
        .out_wr       (out_wr),
        .out_rdy      (out_rdy),
        .mode         (mode),
        .cfg_wr       (cfg_wr),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .cnt_clear    (cnt_clear),
        .fwd_pkt_cnt  (fwd_pkt_cnt),
        .drop_pkt_cnt (drop_pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every out_wr pops the oldest expected word.
    always @(negedge clk) begin
        if (out_wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h expected nothing", {out_ctrl, out_data});
            end else begin
                chk("out_word", {out_ctrl, out_data}, exp_q.pop_front());
            end
        end
    end

    task automatic drive_word(input logic [63:0] d, input logic [7:0] c,
                              input bit keep, input logic [63:0] ed);
        int n = 0;
        while (!in_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            chk("in_rdy_timeout", 72'(in_rdy), 72'd1);
        end
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
        if (keep) exp_q.push_back({c, ed});
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    function automatic logic [63:0] mk_hdr(input logic [15:0] tag, input logic [15:0] src,
                                           input logic [15:0] dst);
        return {tag, 16'h1234, src, dst};
    endfunction

    task automatic send_pkt(input logic [15:0] src, input logic [15:0] dst,
                            input bit fwd, input logic [15:0] tag);
        drive_word(mk_hdr(tag, src, 16'hBEEF), 8'hff, fwd, mk_hdr(tag, src, dst));
        drive_word({tag, 48'h1111_2222_3333}, 8'h00, fwd, {tag, 48'h1111_2222_3333});
        drive_word({tag, 48'hEEEE_0000_0001}, 8'h01, fwd, {tag, 48'hEEEE_0000_0001});
        if (fwd) exp_fwd++;
        else     exp_drop++;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_addr = a;
        cfg_data = d;
        cfg_wr   = 1'b1;
        @(negedge clk);
        cfg_wr   = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            chk({name, "_drain_timeout"}, 72'(exp_q.size()), 72'd0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
        chk({name, "_fwd_cnt"},  72'(fwd_pkt_cnt),  72'(exp_fwd));
        chk({name, "_drop_cnt"}, 72'(drop_pkt_cnt), 72'(exp_drop));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{2'd0, 16'd2,     16'h0008, 1'b1};
        vecs[1]  = '{2'd0, 16'd5,     16'h0010, 1'b1};
        vecs[2]  = '{2'd0, 16'd0,     16'h0002, 1'b1};
        vecs[3]  = '{2'd0, 16'd7,     16'h0040, 1'b1};
        vecs[4]  = '{2'd0, 16'hffff,  16'hBEEF, 1'b1};
        vecs[5]  = '{2'd0, 16'd8,     16'h0000, 1'b0};
        vecs[6]  = '{2'd1, 16'd3,     16'h0005, 1'b1};
        vecs[7]  = '{2'd1, 16'd4,     16'h0000, 1'b0};
        vecs[8]  = '{2'd1, 16'd6,     16'h0080, 1'b1};
        vecs[9]  = '{2'd2, 16'd6,     16'h0040, 1'b1};
        vecs[10] = '{2'd2, 16'd9,     16'h0000, 1'b0};
        vecs[11] = '{2'd3, 16'd1,     16'h0000, 1'b0};
        vecs[12] = '{2'd3, 16'hffff,  16'hBEEF, 1'b1};
        vecs[13] = '{2'd1, 16'hffff,  16'hBEEF, 1'b1};

        reset = 1'b1; in_data = '0; in_ctrl = '0; in_wr = 1'b0; out_rdy = 1'b1;
        mode = 2'd0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0; cnt_clear = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_wr", 72'(out_wr), 72'd0);
        chk("rst_fwd", 72'(fwd_pkt_cnt), 72'd0);
        chk("rst_drop", 72'(drop_pkt_cnt), 72'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_rdy", 72'(in_rdy), 72'd1);

        // Latency: first out_wr two cycles after the first in_wr.
        drive_word(mk_hdr(16'h0001, 16'd2, 16'hBEEF), 8'hff, 1'b1, mk_hdr(16'h0001, 16'd2, 16'h0008));
        chk("lat_1cyc", 72'(out_wr), 72'd0);
        drive_word(64'h0001_0000_0000_00AA, 8'h00, 1'b1, 64'h0001_0000_0000_00AA);
        chk("lat_2cyc", 72'(out_wr), 72'd1);
        drive_word(64'h0001_0000_0000_00BB, 8'h01, 1'b1, 64'h0001_0000_0000_00BB);
        exp_fwd++;
        drain("latency");

        cfg_write(3'd3, 8'h05);
        cfg_write(3'd6, 8'h80);
        for (int i = 0; i < 14; i++) begin
            mode = vecs[i].mode;
            send_pkt(vecs[i].src, vecs[i].dst, vecs[i].fwd, 16'(16'h0100 + i));
        end
        drain("vectors");

        // Two drops back to back; mode flips to NIC inside the second drop.
        mode = 2'd3;
        send_pkt(16'd1, 16'h0000, 1'b0, 16'h0200);
        drive_word(mk_hdr(16'h0201, 16'd2, 16'hBEEF), 8'hff, 1'b0, '0);
        mode = 2'd0;
        drive_word(64'h0201_0000_0000_0001, 8'h00, 1'b0, '0);
        drive_word(64'h0201_0000_0000_0002, 8'h01, 1'b0, '0);
        exp_drop++;
        send_pkt(16'd4, 16'h0020, 1'b1, 16'h0202);
        drain("drop_then_nic");

        // Same-cycle table write and lookup of entry 5 sees the old (zero) row.
        mode = 2'd1;
        cfg_addr = 3'd5; cfg_data = 8'h10; cfg_wr = 1'b1;
        drive_word(mk_hdr(16'h0300, 16'd5, 16'hBEEF), 8'hff, 1'b0, '0);
        cfg_wr = 1'b0;
        drive_word(64'h0300_0000_0000_0001, 8'h00, 1'b0, '0);
        drive_word(64'h0300_0000_0000_0002, 8'h01, 1'b0, '0);
        exp_drop++;
        send_pkt(16'd5, 16'h0010, 1'b1, 16'h0301);
        drain("tbl_same_cycle");

        // Backpressure until in_rdy falls, then release.
        mode = 2'd0;
        out_rdy = 1'b0;
        send_pkt(16'd0, 16'h0002, 1'b1, 16'h0400);
        chk("bp_in_rdy", 72'(in_rdy), 72'd0);
        repeat (4) @(negedge clk);
        chk("bp_out_wr", 72'(out_wr), 72'd0);
        out_rdy = 1'b1;
        send_pkt(16'd7, 16'h0040, 1'b1, 16'h0401);
        drain("backpressure");

        // Reset in the middle of a packet.
        drive_word(mk_hdr(16'h0500, 16'd6, 16'hBEEF), 8'hff, 1'b1, mk_hdr(16'h0500, 16'd6, 16'h0080));
        drive_word(64'h0500_0000_0000_0001, 8'h00, 1'b1, 64'h0500_0000_0000_0001);
        #1;
        reset = 1'b1;
        exp_q.delete();
        exp_fwd = 0;
        exp_drop = 0;
        @(negedge clk);
        chk("midrst_out_wr", 72'(out_wr), 72'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_fwd", 72'(fwd_pkt_cnt), 72'd0);
        chk("midrst_drop", 72'(drop_pkt_cnt), 72'd0);
        send_pkt(16'd3, 16'h0004, 1'b1, 16'h0501);
        drain("after_reset");

        // Counter clear coincident with a drop increment.
        mode = 2'd3;
        cnt_clear = 1'b1;
        drive_word(mk_hdr(16'h0600, 16'd2, 16'hBEEF), 8'hff, 1'b0, '0);
        cnt_clear = 1'b0;
        drive_word(64'h0600_0000_0000_0001, 8'h00, 1'b0, '0);
        drive_word(64'h0600_0000_0000_0002, 8'h01, 1'b0, '0);
        exp_fwd = 0;
        exp_drop = 0;
        drain("clear_vs_drop");
        mode = 2'd0;
        send_pkt(16'd1, 16'h0001, 1'b1, 16'h0601);
        drain("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ioq_port_map_lookup.md
Name: ioq_port_map_lookup

Overview:
- Parametrised output-port lookup stage in the user data path, between input arbiter and output queues.
- Rewrites the IOQ module-header destination field from the source-port field, according to a run-time mode: NIC pairing, programmable per-source table, loopback, or drop-all.
- Discards whole packets whose computed destination mask is zero.
- Keeps forwarded and dropped packet counters; buffers output in a small FIFO with the standard out_wr/out_rdy handshake.

Parameters:
DATA_WIDTH, 64, data word width
CTRL_WIDTH, DATA_WIDTH/8, ctrl word width
NUM_PORTS, 8, total ports (even = MAC, odd = CPU); 2..16, even
IO_QUEUE_STAGE_NUM, 8'hff, ctrl value tagging the IOQ header word
IOQ_DST_PORT_POS, 0, LSB of 16-bit one-hot destination field
IOQ_SRC_PORT_POS, 16, LSB of 16-bit binary source field
FIFO_DEPTH_BITS, 2, log2 of output FIFO depth
CNT_WIDTH, 32, counter width

Ports:
clk  in  1  clock
reset  in  1  sync active-high reset
in_data  in  DATA_WIDTH  input word
in_ctrl  in  CTRL_WIDTH  input ctrl
in_wr  in  1  input word valid
in_rdy  out  1  stage can accept a word
out_data  out  DATA_WIDTH  output word
out_ctrl  out  CTRL_WIDTH  output ctrl
out_wr  out  1  output word valid
out_rdy  in  1  downstream can accept
mode  in  2  0=NIC, 1=TABLE, 2=LOOPBACK, 3=DROP_ALL
cfg_wr  in  1  table write strobe
cfg_addr  in  log2(NUM_PORTS)  table entry (source port)
cfg_data  in  NUM_PORTS  destination mask for entry
cnt_clear  in  1  zero both counters
fwd_pkt_cnt  out  CNT_WIDTH  packets forwarded
drop_pkt_cnt  out  CNT_WIDTH  packets dropped

Behaviour:
- Reset is reset, synchronous, active-high; clock is clk.
- Reset state:
  - out_wr = 0; counters = 0; all table entries = 0; FIFO empty; FSM = HDR.
- in_rdy = !fifo_nearly_full, combinational.
- Upstream never writes when in_rdy = 0; a violation is undefined.
- Destination mask computed on the IOQ header word (in_wr && in_ctrl == IO_QUEUE_STAGE_NUM). Let s = the source field.
  - s == 16'hffff: pass the word unmodified, count as forwarded.
  - s >= NUM_PORTS: mask = 0.
  - NIC: s odd -> bit s-1; s even -> bit s+1.
  - TABLE: mask = table[s].
  - LOOPBACK: mask = bit s.
  - DROP_ALL: mask = 0.
  - Mask is zero-extended to 16 bits and written to the destination field. All other bits are unchanged.
- FSM states:
  - HDR: words are written to the FIFO.
    - IOQ word with mask != 0: write the modified word, fwd_pkt_cnt++.
    - IOQ word with mask == 0: do not write, drop_pkt_cnt++, go to DROP_HDR.
    - in_ctrl == 0: go to PKT.
  - PKT: words are written.
    - in_ctrl != 0 (EOP word, written): go to HDR.
  - DROP_HDR: nothing is written.
    - in_ctrl == 0: go to DROP_PKT.
  - DROP_PKT: nothing is written.
    - in_ctrl != 0 (EOP, discarded): go to HDR.
- An IOQ word must be the first word of a packet. Earlier module headers are not retracted.
- Transitions occur only on cycles with in_wr = 1.
- The mode is sampled on the IOQ word only. A mode change mid-packet does not affect the current packet.
- Table write lands on the posedge. A same-cycle lookup of the same entry uses the old value.
- Output side:
  - fifo_rd = out_rdy && !fifo_empty.
  - out_wr <= reset ? 0 : fifo_rd.
  - out_data/out_ctrl are the FIFO dout, valid in the cycle out_wr = 1.
  - Minimum latency from in_wr to out_wr is 2 cycles.
- Counters wrap at 2^CNT_WIDTH.
- cnt_clear has priority over a same-cycle increment; the result is 0.
- Reset mid-packet: FSM returns to HDR, FIFO contents are lost, the next word is treated as a header.

Decomposition:
- Package ioq_lookup_pkg holds:
  - mode encodings MODE_NIC/TABLE/LOOPBACK/DROP_ALL;
  - state encodings;
  - the 16'hffff bypass constant.
- Existing small_fifo is instantiated as the output buffer (width CTRL_WIDTH+DATA_WIDTH, depth bits FIFO_DEPTH_BITS).
- One new sub-module: ioq_dst_calc, a combinational mask computation from s, mode, and the table row.

Test Plan:
- NIC mode, 3-word packet (IOQ hdr s=2, one data word, EOP ctrl=8'h01), out_rdy=1 -> IOQ word dst field 16'h0008; 3 out_wr pulses, the first 2 cycles after the first in_wr; fwd_pkt_cnt=1.
- NIC mode, s=5 -> dst 16'h0010; s=16'hffff -> header unchanged, fwd_pkt_cnt increments.
- TABLE mode:
  - cfg_wr addr 3 data 8'h05, then packet s=3 -> dst 16'h0005.
  - Entry 4 left 0, packet s=4 -> no out_wr for the whole packet, drop_pkt_cnt=1.
  - Next packet forwarded normally.
- DROP_ALL for 2 packets, then NIC without gaps -> exactly 2 drops and the third packet forwarded intact; mode switched to NIC mid-drop still completes the drop.
- Backpressure: out_rdy=0 until in_rdy falls -> no words lost or duplicated after out_rdy=1; output order matches input.
- Reset asserted mid-PKT, then a fresh packet -> counters 0, out_wr 0 during reset, new packet forwarded with a correct header rewrite; cnt_clear coincident with a drop -> drop_pkt_cnt=0.
